// File: rtl/ucsbece154b_bpctrl_if.sv
// Signal bundle between the datapath/hazard unit and the branch-prediction controller.
// The controller uses the slave view; whoever drives fetch/execute info uses master.
interface ucsbece154b_bpctrl_if #(
    parameter int NUM_GHR_BITS    = 6,
    parameter int NUM_BTB_ENTRIES = 64,
    parameter int CNT_WIDTH       = 32
);
    localparam int IW = $clog2(NUM_BTB_ENTRIES);

    logic [31:0]             PCF_i;
    logic                    BranchTakenF_i;
    logic [31:0]             BTBtargetF_i;
    logic [NUM_GHR_BITS-1:0] PHTreadaddrF_i;
    logic                    StallD_i;
    logic                    FlushD_i;
    logic                    FlushE_i;
    logic                    BranchE_i;
    logic                    JumpE_i;
    logic                    TakenE_i;
    logic [31:0]             PCTargetE_i;
    logic [31:0]             PCPlus4E_i;
    logic                    MispredictE_o;
    logic [31:0]             RedirectPC_o;
    logic                    BTBwe_o;
    logic [IW-1:0]           BTBwriteaddress_o;
    logic [31:0]             BTBwritedata_o;
    logic                    PHTwe_o;
    logic                    PHTincrement_o;
    logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
    logic                    GHRreset_o;
    logic                    CntClear_i;
    logic [CNT_WIDTH-1:0]    BranchCount_o;
    logic [CNT_WIDTH-1:0]    MispredCount_o;

    modport slave (
        input  PCF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddrF_i,
        input  StallD_i, FlushD_i, FlushE_i,
        input  BranchE_i, JumpE_i, TakenE_i, PCTargetE_i, PCPlus4E_i,
        input  CntClear_i,
        output MispredictE_o, RedirectPC_o,
        output BTBwe_o, BTBwriteaddress_o, BTBwritedata_o,
        output PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o,
        output BranchCount_o, MispredCount_o
    );

    modport master (
        output PCF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddrF_i,
        output StallD_i, FlushD_i, FlushE_i,
        output BranchE_i, JumpE_i, TakenE_i, PCTargetE_i, PCPlus4E_i,
        output CntClear_i,
        input  MispredictE_o, RedirectPC_o,
        input  BTBwe_o, BTBwriteaddress_o, BTBwritedata_o,
        input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o,
        input  BranchCount_o, MispredCount_o
    );
endinterface

// File: rtl/ucsbece154b_bpctrl.sv
// Branch-prediction controller: carries F-stage predictions to E, resolves them,
// and emits redirect plus BTB/PHT/GHR update strobes and perf counters.
module ucsbece154b_bpctrl #(
    parameter int NUM_GHR_BITS    = 6,
    parameter int NUM_BTB_ENTRIES = 64,
    parameter int CNT_WIDTH       = 32
) (
    input  logic clk,
    input  logic reset,
    ucsbece154b_bpctrl_if.slave bp
);
    localparam int IW = $clog2(NUM_BTB_ENTRIES);

    logic                    valid_d_q, valid_d_d, pred_d_q, pred_d_d;
    logic [31:0]             tgt_d_q, tgt_d_d;
    logic [NUM_GHR_BITS-1:0] pht_d_q, pht_d_d;
    logic [IW-1:0]           pc_d_q, pc_d_d;

    logic                    valid_e_q, valid_e_d, pred_e_q, pred_e_d;
    logic [31:0]             tgt_e_q, tgt_e_d;
    logic [NUM_GHR_BITS-1:0] pht_e_q, pht_e_d;
    logic [IW-1:0]           pc_e_q, pc_e_d;

    logic [CNT_WIDTH-1:0]    brcnt_q, brcnt_d, miscnt_q, miscnt_d;
    logic                    act_t, mis;

    always_comb begin
        valid_d_d = valid_d_q;
        pred_d_d  = pred_d_q;
        tgt_d_d   = tgt_d_q;
        pht_d_d   = pht_d_q;
        pc_d_d    = pc_d_q;
        if (bp.FlushD_i) begin
            valid_d_d = 1'b0;
        end else if (!bp.StallD_i) begin
            valid_d_d = 1'b1;
            pred_d_d  = bp.BranchTakenF_i;
            tgt_d_d   = bp.BTBtargetF_i;
            pht_d_d   = bp.PHTreadaddrF_i;
            pc_d_d    = bp.PCF_i[IW+1:2];
        end

        valid_e_d = bp.FlushE_i ? 1'b0 : valid_d_q;
        pred_e_d  = pred_d_q;
        tgt_e_d   = tgt_d_q;
        pht_e_d   = pht_d_q;
        pc_e_d    = pc_d_q;
    end

    // A wrong target on a correctly-predicted taken transfer is also a redirect.
    always_comb begin
        act_t = (bp.BranchE_i & bp.TakenE_i) | bp.JumpE_i;
        mis   = valid_e_q & ((pred_e_q ^ act_t) |
                (pred_e_q & act_t & (tgt_e_q != bp.PCTargetE_i)));

        bp.MispredictE_o     = mis;
        bp.RedirectPC_o      = '0;
        bp.BTBwe_o           = valid_e_q & act_t;
        bp.BTBwriteaddress_o = '0;
        bp.BTBwritedata_o    = '0;
        bp.PHTwe_o           = valid_e_q & bp.BranchE_i;
        bp.PHTincrement_o    = valid_e_q & bp.BranchE_i & bp.TakenE_i;
        bp.PHTwriteaddress_o = '0;
        bp.GHRreset_o        = bp.BranchE_i & mis;
        if (valid_e_q) begin
            bp.RedirectPC_o      = act_t ? bp.PCTargetE_i : bp.PCPlus4E_i;
            bp.BTBwriteaddress_o = pc_e_q;
            bp.BTBwritedata_o    = bp.PCTargetE_i;
            bp.PHTwriteaddress_o = pht_e_q;
        end
    end

    always_comb begin
        brcnt_d  = brcnt_q;
        miscnt_d = miscnt_q;
        if (bp.CntClear_i) begin
            brcnt_d  = '0;
            miscnt_d = '0;
        end else begin
            if (valid_e_q && bp.BranchE_i && (brcnt_q != '1))
                brcnt_d = brcnt_q + 1'b1;
            if (mis && (miscnt_q != '1))
                miscnt_d = miscnt_q + 1'b1;
        end
        bp.BranchCount_o  = brcnt_q;
        bp.MispredCount_o = miscnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_d_q <= 1'b0;
            pred_d_q  <= 1'b0;
            tgt_d_q   <= '0;
            pht_d_q   <= '0;
            pc_d_q    <= '0;
            valid_e_q <= 1'b0;
            pred_e_q  <= 1'b0;
            tgt_e_q   <= '0;
            pht_e_q   <= '0;
            pc_e_q    <= '0;
            brcnt_q   <= '0;
            miscnt_q  <= '0;
        end else begin
            valid_d_q <= valid_d_d;
            pred_d_q  <= pred_d_d;
            tgt_d_q   <= tgt_d_d;
            pht_d_q   <= pht_d_d;
            pc_d_q    <= pc_d_d;
            valid_e_q <= valid_e_d;
            pred_e_q  <= pred_e_d;
            tgt_e_q   <= tgt_e_d;
            pht_e_q   <= pht_e_d;
            pc_e_q    <= pc_e_d;
            brcnt_q   <= brcnt_d;
            miscnt_q  <= miscnt_d;
        end
    end
endmodule

// File: tb/tb_ucsbece154b_bpctrl.sv
// Directed and randomized checks of ucsbece154b_bpctrl against an
// instruction-level model of the D/E tracking and outcome rules.
module tb_ucsbece154b_bpctrl;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ucsbece154b_bpctrl_if #(
        .NUM_GHR_BITS(6), .NUM_BTB_ENTRIES(64), .CNT_WIDTH(CW)
    ) bp ();

    ucsbece154b_bpctrl #(
        .NUM_GHR_BITS(6), .NUM_BTB_ENTRIES(64), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bp(bp)
    );

    typedef struct {
        bit        v;
        bit        pred;
        bit [31:0] tgt;
        bit [5:0]  pht;
        bit [31:0] pc;
    } slot_t;

    slot_t md, me;
    int mb, mm;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_act();
        return (bp.BranchE_i && bp.TakenE_i) || bp.JumpE_i;
    endfunction

    function automatic bit m_mis();
        bit a = m_act();
        if (!me.v) return 1'b0;
        if (me.pred != a) return 1'b1;
        return me.pred && a && (me.tgt != bp.PCTargetE_i);
    endfunction

    task automatic model_reset();
        md = '{0, 0, 0, 0, 0};
        me = '{0, 0, 0, 0, 0};
        mb = 0;
        mm = 0;
    endtask

    task automatic check_outs(input string tag);
        bit v = me.v;
        bit a = m_act();
        bit mi = m_mis();
        chk({tag, ".mis"}, 32'(bp.MispredictE_o), 32'(mi));
        chk({tag, ".rpc"}, bp.RedirectPC_o,
            !v ? 32'h0 : (a ? bp.PCTargetE_i : bp.PCPlus4E_i));
        chk({tag, ".btbwe"}, 32'(bp.BTBwe_o), 32'(v && a));
        chk({tag, ".phtwe"}, 32'(bp.PHTwe_o), 32'(v && bp.BranchE_i));
        chk({tag, ".inc"}, 32'(bp.PHTincrement_o), 32'(v && bp.BranchE_i && bp.TakenE_i));
        chk({tag, ".ghr"}, 32'(bp.GHRreset_o), 32'(bp.BranchE_i && mi));
        if (v) begin
            chk({tag, ".phta"}, 32'(bp.PHTwriteaddress_o), 32'(me.pht));
            chk({tag, ".btba"}, 32'(bp.BTBwriteaddress_o), (me.pc >> 2) % 64);
            chk({tag, ".btbd"}, bp.BTBwritedata_o, bp.PCTargetE_i);
        end
    endtask

    task automatic tick();
        bit mi;
        @(posedge clk);
        if (reset) begin
            mi = m_mis();
            if (bp.CntClear_i) begin
                mb = 0;
                mm = 0;
            end else begin
                if (me.v && bp.BranchE_i && mb < CMAX) mb++;
                if (mi && mm < CMAX) mm++;
            end
            if (bp.FlushE_i) me.v = 0;
            else me = md;
            if (bp.FlushD_i) md.v = 0;
            else if (!bp.StallD_i)
                md = '{1, bp.BranchTakenF_i, bp.BTBtargetF_i,
                       bp.PHTreadaddrF_i, bp.PCF_i};
        end
        #1;
        chk("bcnt", 32'(bp.BranchCount_o), 32'(mb));
        chk("mcnt", 32'(bp.MispredCount_o), 32'(mm));
        @(negedge clk);
    endtask

    task automatic step(input string tag);
        #1;
        check_outs(tag);
        tick();
    endtask

    task automatic set_f(input logic [31:0] pc, input logic p,
                         input logic [31:0] t, input logic [5:0] h);
        bp.PCF_i = pc;
        bp.BranchTakenF_i = p;
        bp.BTBtargetF_i = t;
        bp.PHTreadaddrF_i = h;
    endtask

    task automatic set_e(input logic b, input logic j, input logic tk,
                         input logic [31:0] t, input logic [31:0] p4);
        bp.BranchE_i = b;
        bp.JumpE_i = j;
        bp.TakenE_i = tk;
        bp.PCTargetE_i = t;
        bp.PCPlus4E_i = p4;
    endtask

    initial begin
        int pb;
        model_reset();
        set_f(0, 0, 0, 0);
        set_e(0, 0, 0, 0, 0);
        bp.StallD_i = 0;
        bp.FlushD_i = 0;
        bp.FlushE_i = 0;
        bp.CntClear_i = 0;
        repeat (2) @(negedge clk);
        #1;
        check_outs("rst");
        chk("rst.bcnt", 32'(bp.BranchCount_o), 0);
        reset = 1;
        @(negedge clk);

        // not-taken prediction, taken branch
        set_f(32'h104, 0, 0, 6'h2A);
        step("nt_f");
        set_f(32'h108, 0, 0, 6'h00);
        step("nt_d");
        set_e(1, 0, 1, 32'h140, 32'h108);
        #1;
        chk("nt.mis", 32'(bp.MispredictE_o), 1);
        chk("nt.rpc", bp.RedirectPC_o, 32'h140);
        chk("nt.phta", 32'(bp.PHTwriteaddress_o), 32'h2A);
        chk("nt.btba", 32'(bp.BTBwriteaddress_o), 1);
        chk("nt.ghr", 32'(bp.GHRreset_o), 1);
        step("nt_e");
        chk("nt.mcnt", 32'(bp.MispredCount_o), 1);
        chk("nt.bcnt", 32'(bp.BranchCount_o), 1);

        // correctly predicted taken branch
        set_e(0, 0, 0, 0, 0);
        set_f(32'h110, 1, 32'h140, 6'h05);
        step("tk_f");
        set_f(32'h114, 0, 0, 0);
        step("tk_d");
        set_e(1, 0, 1, 32'h140, 32'h114);
        #1;
        chk("tk.mis", 32'(bp.MispredictE_o), 0);
        chk("tk.ghr", 32'(bp.GHRreset_o), 0);
        chk("tk.phtwe", 32'(bp.PHTwe_o), 1);
        chk("tk.btbwe", 32'(bp.BTBwe_o), 1);
        step("tk_e");

        // stall holds the D-stage prediction
        set_e(0, 0, 0, 0, 0);
        set_f(32'h120, 0, 0, 6'h2A);
        step("st_f");
        bp.StallD_i = 1;
        set_f(32'h124, 0, 0, 6'h11);
        step("st_1");
        step("st_2");
        bp.StallD_i = 0;
        step("st_3");
        set_e(1, 0, 0, 32'h180, 32'h124);
        #1;
        chk("st.phta", 32'(bp.PHTwriteaddress_o), 32'h2A);
        step("st_e");

        // FlushE with a branch in D
        set_e(0, 0, 0, 0, 0);
        set_f(32'h130, 0, 0, 6'h07);
        step("fe_f");
        bp.FlushE_i = 1;
        set_f(32'h134, 0, 0, 0);
        step("fe_d");
        bp.FlushE_i = 0;
        pb = mb;
        set_e(1, 0, 1, 32'h150, 32'h134);
        #1;
        chk("fe.phtwe", 32'(bp.PHTwe_o), 0);
        chk("fe.btbwe", 32'(bp.BTBwe_o), 0);
        chk("fe.mis", 32'(bp.MispredictE_o), 0);
        step("fe_e");
        chk("fe.bcnt", 32'(bp.BranchCount_o), 32'(pb));

        // BTB alias on a non-branch
        set_e(0, 0, 0, 0, 0);
        set_f(32'h308, 1, 32'h200, 6'h09);
        step("al_f");
        set_f(32'h30C, 0, 0, 0);
        step("al_d");
        set_e(0, 0, 0, 32'h200, 32'h30C);
        #1;
        chk("al.mis", 32'(bp.MispredictE_o), 1);
        chk("al.rpc", bp.RedirectPC_o, 32'h30C);
        chk("al.phtwe", 32'(bp.PHTwe_o), 0);
        chk("al.btbwe", 32'(bp.BTBwe_o), 0);
        chk("al.ghr", 32'(bp.GHRreset_o), 0);
        step("al_e");

        // saturation, then clear racing an increment
        set_e(0, 0, 0, 0, 32'h404);
        for (int i = 0; i < 20; i++) begin
            set_f(32'h400 + 32'(i * 4), 1, 32'h800, 6'(i));
            step("sat");
        end
        chk("sat.mcnt", 32'(bp.MispredCount_o), 15);
        bp.CntClear_i = 1;
        step("clr");
        bp.CntClear_i = 0;
        chk("clr.mcnt", 32'(bp.MispredCount_o), 0);
        chk("clr.bcnt", 32'(bp.BranchCount_o), 0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            set_f({$urandom_range(0, 1023), 2'b00}, 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80,
                  6'($urandom));
            bp.BranchE_i = 1'($urandom);
            bp.JumpE_i = !bp.BranchE_i && ($urandom_range(0, 3) == 0);
            bp.TakenE_i = 1'($urandom);
            bp.PCTargetE_i = ($urandom_range(0, 1) != 0) ? 32'h40 : 32'h80;
            bp.PCPlus4E_i = {$urandom_range(0, 1023), 2'b00};
            bp.StallD_i = ($urandom_range(0, 7) == 0);
            bp.FlushD_i = ($urandom_range(0, 7) == 0);
            bp.FlushE_i = ($urandom_range(0, 7) == 0);
            bp.CntClear_i = ($urandom_range(0, 63) == 0);
            step("rnd");
        end
        bp.StallD_i = 0;
        bp.FlushD_i = 0;
        bp.FlushE_i = 0;
        bp.CntClear_i = 0;

        // reset mid-cycle with a branch in E
        set_f(32'h500, 0, 0, 6'h3);
        step("mr_f");
        step("mr_d");
        set_e(1, 0, 1, 32'h540, 32'h504);
        #3;
        reset = 0;
        model_reset();
        #1;
        chk("mr.mis", 32'(bp.MispredictE_o), 0);
        chk("mr.rpc", bp.RedirectPC_o, 0);
        chk("mr.phtwe", 32'(bp.PHTwe_o), 0);
        chk("mr.btbwe", 32'(bp.BTBwe_o), 0);
        chk("mr.btbd", bp.BTBwritedata_o, 0);
        chk("mr.phta", 32'(bp.PHTwriteaddress_o), 0);
        chk("mr.mcnt", 32'(bp.MispredCount_o), 0);
        chk("mr.bcnt", 32'(bp.BranchCount_o), 0);
        @(negedge clk);
        reset = 1;
        step("mr_1");
        chk("mr1.phtwe", 32'(bp.PHTwe_o), 0);
        step("mr_2");
        check_outs("mr_3");
        chk("mr3.phtwe", 32'(bp.PHTwe_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
